// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern generator (OFF/ON/BLINK/BREATHE) with a tick-enable prescaler and a
// valid/ready configuration port. Define LED_ACTIVE_LOW_EN for inverted (sink-driven) LED outputs.
module led_pattern_ctrl #(
    parameter int CLK_FREQ  = 200_000_000,
    parameter int TICK_FREQ = 1_000,
    parameter int NUM_CH    = 8,
    parameter int PER_W     = 8,
    parameter int PWM_BITS  = 6,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [PER_W-1:0]  cfg_period,
    output logic              tick,
    output logic [NUM_CH-1:0] leds
);

    localparam int DIV   = CLK_FREQ / TICK_FREQ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_bad_div
        $fatal(1, "led_pattern_ctrl: CLK_FREQ/TICK_FREQ must be at least 2");
    end
    if (NUM_CH < 1) begin : g_bad_ch
        $fatal(1, "led_pattern_ctrl: NUM_CH must be at least 1");
    end

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_ON      = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [0:0] ST_IDLE      = 1'b0;
    localparam logic [0:0] ST_PEND      = 1'b1;
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    localparam logic [CH_W:0] NUM_CH_L  = (CH_W + 1)'(NUM_CH);

`ifdef LED_ACTIVE_LOW_EN
    localparam logic LED_INV = 1'b1;
`else
    localparam logic LED_INV = 1'b0;
`endif

    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_q;
    logic [0:0]          state_q, state_d;
    logic [CH_W-1:0]     pend_ch_q, pend_ch_d;
    logic [1:0]          pend_mode_q, pend_mode_d;
    logic [PER_W-1:0]    pend_per_q, pend_per_d;
    logic                apply_w;

    logic [1:0]          mode_q  [NUM_CH];
    logic [1:0]          mode_d  [NUM_CH];
    logic [PER_W-1:0]    per_q   [NUM_CH];
    logic [PER_W-1:0]    per_d   [NUM_CH];
    logic [PER_W-1:0]    cnt_q   [NUM_CH];
    logic [PER_W-1:0]    cnt_d   [NUM_CH];
    logic [PWM_BITS-1:0] duty_q  [NUM_CH];
    logic [PWM_BITS-1:0] duty_d  [NUM_CH];
    logic                dir_q   [NUM_CH];
    logic                dir_d   [NUM_CH];
    logic                blink_q [NUM_CH];
    logic                blink_d [NUM_CH];
    logic [NUM_CH-1:0]   led_d, leds_q;

    assign tick      = (presc_q == PRE_W'(DIV - 1));
    assign presc_d   = tick ? '0 : presc_q + 1'b1;
    assign cfg_ready = (state_q == ST_IDLE);
    assign leds      = leds_q;

    always_comb begin
        state_d     = state_q;
        pend_ch_d   = pend_ch_q;
        pend_mode_d = pend_mode_q;
        pend_per_d  = pend_per_q;
        apply_w     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    state_d     = ST_PEND;
                    pend_ch_d   = cfg_ch;
                    pend_mode_d = cfg_mode;
                    pend_per_d  = cfg_period;
                end
            end
            default: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    apply_w = ({1'b0, pend_ch_q} < NUM_CH_L);
                end
            end
        endcase
    end

    // dir=1 means duty is ramping down; the apply tick replaces the step for the written channel
    always_comb begin
        led_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            mode_d[i]  = mode_q[i];
            per_d[i]   = per_q[i];
            cnt_d[i]   = cnt_q[i];
            duty_d[i]  = duty_q[i];
            dir_d[i]   = dir_q[i];
            blink_d[i] = blink_q[i];
            if (apply_w && (pend_ch_q == CH_W'(i))) begin
                mode_d[i]  = pend_mode_q;
                per_d[i]   = pend_per_q;
                cnt_d[i]   = '0;
                duty_d[i]  = '0;
                dir_d[i]   = 1'b0;
                blink_d[i] = 1'b0;
            end else if (tick) begin
                if (cnt_q[i] == per_q[i]) begin
                    cnt_d[i] = '0;
                    if (mode_q[i] == MODE_BLINK) begin
                        blink_d[i] = ~blink_q[i];
                    end else if (mode_q[i] != MODE_OFF && mode_q[i] != MODE_ON) begin
                        if (!dir_q[i]) begin
                            if (duty_q[i] == DUTY_MAX) begin
                                dir_d[i]  = 1'b1;
                                duty_d[i] = duty_q[i] - 1'b1;
                            end else begin
                                duty_d[i] = duty_q[i] + 1'b1;
                            end
                        end else begin
                            if (duty_q[i] == '0) begin
                                dir_d[i]  = 1'b0;
                                duty_d[i] = duty_q[i] + 1'b1;
                            end else begin
                                duty_d[i] = duty_q[i] - 1'b1;
                            end
                        end
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            case (mode_q[i])
                MODE_OFF:   led_d[i] = 1'b0;
                MODE_ON:    led_d[i] = 1'b1;
                MODE_BLINK: led_d[i] = blink_q[i];
                default:    led_d[i] = (pwm_q < duty_q[i]);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            pwm_q       <= '0;
            state_q     <= ST_IDLE;
            pend_ch_q   <= '0;
            pend_mode_q <= '0;
            pend_per_q  <= '0;
            leds_q      <= {NUM_CH{LED_INV}};
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                mode_q[i]  <= MODE_OFF;
                per_q[i]   <= '0;
                cnt_q[i]   <= '0;
                duty_q[i]  <= '0;
                dir_q[i]   <= 1'b0;
                blink_q[i] <= 1'b0;
            end
        end else begin
            presc_q     <= presc_d;
            pwm_q       <= pwm_q + 1'b1;
            state_q     <= state_d;
            pend_ch_q   <= pend_ch_d;
            pend_mode_q <= pend_mode_d;
            pend_per_q  <= pend_per_d;
            leds_q      <= led_d ^ {NUM_CH{LED_INV}};
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                mode_q[i]  <= mode_d[i];
                per_q[i]   <= per_d[i];
                cnt_q[i]   <= cnt_d[i];
                duty_q[i]  <= duty_d[i];
                dir_q[i]   <= dir_d[i];
                blink_q[i] <= blink_d[i];
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl; channel outputs are predicted from tick counts since each write.
module tb_led_pattern_ctrl;

    localparam int CLK_FREQ  = 1000;
    localparam int TICK_FREQ = 100;
    localparam int NUM_CH    = 6;
    localparam int PER_W     = 4;
    localparam int PWM_BITS  = 3;
    localparam int CH_W      = 3;
    localparam int DIV       = CLK_FREQ / TICK_FREQ;
    localparam int DMAX      = (1 << PWM_BITS) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [1:0]        cfg_mode = '0;
    logic [PER_W-1:0]  cfg_period = '0;
    logic              tick;
    logic [NUM_CH-1:0] leds;

    always #5 clk = ~clk;

    led_pattern_ctrl #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_FREQ(TICK_FREQ),
        .NUM_CH   (NUM_CH),
        .PER_W    (PER_W),
        .PWM_BITS (PWM_BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_period(cfg_period),
        .tick      (tick),
        .leds      (leds)
    );

    int checks = 0;
    int errors = 0;

`ifdef LED_ACTIVE_LOW_EN
    logic inv = 1'b1;
`else
    logic inv = 1'b0;
`endif

    // Reference model: e = rising edges since reset release; ticks seen after edge E = E/DIV.
    int                e;
    bit                pend, acc;
    int                p_ch, p_mode, p_per;
    int                m_mode  [NUM_CH];
    int                m_per   [NUM_CH];
    int                m_apply [NUM_CH];
    logic [NUM_CH-1:0] exp_leds;

    function automatic logic led_of(int ch, int ee);
        int steps, ph, duty;
        steps = (ee / DIV - m_apply[ch]) / (m_per[ch] + 1);
        case (m_mode[ch])
            0: return 1'b0;
            1: return 1'b1;
            2: return (steps % 2) == 1;
            default: begin
                ph   = steps % (2 * DMAX);
                duty = (ph <= DMAX) ? ph : 2 * DMAX - ph;
                return (ee % (1 << PWM_BITS)) < duty;
            end
        endcase
    endfunction

    task automatic model_edge();
        for (int c = 0; c < NUM_CH; c++) exp_leds[c] = led_of(c, e) ^ inv;
        if (pend) begin
            if (e % DIV == DIV - 1) begin
                if (p_ch < NUM_CH) begin
                    m_mode[p_ch]  = p_mode;
                    m_per[p_ch]   = p_per;
                    m_apply[p_ch] = (e + 1) / DIV;
                end
                pend = 0;
            end
        end else if (cfg_valid) begin
            pend   = 1;
            acc    = 1;
            p_ch   = int'(cfg_ch);
            p_mode = int'(cfg_mode);
            p_per  = int'(cfg_period);
        end
        e++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("leds", 32'(leds), 32'(exp_leds));
        chk("tick", 32'(tick), 32'(e % DIV == DIV - 1));
        chk("cfg_ready", 32'(cfg_ready), 32'(!pend));
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        #1;
        chk("rst_leds", 32'(leds), 32'({NUM_CH{inv}}));
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_tick", 32'(tick), 32'd0);
        e    = 0;
        pend = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c]  = 0;
            m_per[c]   = 0;
            m_apply[c] = 0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write(input int ch, input int mode, input int per, input bit drop);
        int n;
        n          = 0;
        cfg_ch     = CH_W'(ch);
        cfg_mode   = 2'(mode);
        cfg_period = PER_W'(per);
        cfg_valid  = 1'b1;
        acc        = 0;
        while (!acc && n < 4 * DIV) begin
            cyc();
            n++;
        end
        if (drop) cfg_valid = 1'b0;
    endtask

    initial begin
        int n;
        @(negedge clk);
        do_reset();

        // first tick lands DIV-1 edges after release
        n = 0;
        while (tick !== 1'b1 && n < 3 * DIV) begin
            cyc();
            n++;
        end
        chk("first_tick_edges", 32'(n), 32'(DIV - 1));
        run(25);

        // BLINK ch2 period 3
        write(2, 2, 3, 1);
        run(90);

        // BREATHE ch1 period 0, full triangle and beyond
        write(1, 3, 0, 1);
        run(180);

        // out-of-range channel is accepted and dropped
        write(NUM_CH, 1, 0, 1);
        run(25);

        // ON then OFF on ch0
        write(0, 1, 0, 1);
        run(15);
        write(0, 0, 0, 1);
        run(15);

        // back-to-back writes with cfg_valid held high
        write(3, 1, 2, 0);
        write(3, 2, 1, 1);
        run(30);

        // write presented on a tick cycle waits a full tick interval
        n = 0;
        while (!(e % DIV == DIV - 1) && n < 3 * DIV) begin
            cyc();
            n++;
        end
        cfg_ch     = CH_W'(4);
        cfg_mode   = 2'd1;
        cfg_period = '0;
        cfg_valid  = 1'b1;
        cyc();
        cfg_valid  = 1'b0;
        n = 0;
        while (cfg_ready === 1'b0 && n < 3 * DIV) begin
            n++;
            cyc();
        end
        chk("tick_write_wait", 32'(n), 32'(DIV));
        run(12);

        // random configuration traffic
        for (int k = 0; k < 8; k++) begin
            write(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1);
            run(int'($urandom_range(5, 60)));
        end

        // reset while a write is pending discards it
        write(5, 1, 0, 1);
        do_reset();
        run(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
